debug_loader: RTL and testbench
===============================

# debug_loader

Host-side control block for the five-stage MIPS pipeline. It turns a byte stream from the UART receiver into instruction-memory writes and run/step/halt control. It drives the fetch stage's PC enable and the pipeline reset, and returns status bytes through the UART transmitter. It is the write/control end of the instruction-memory and PC-enable interface that the fetch stage only reads.

## Interface
- LEN, 32, instruction word width in bits
- ADDR_W, 8, instruction-memory word-address width (256 words)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- in_rx_data  in  8  received byte
- in_rx_done  in  1  one-cycle strobe: in_rx_data valid
- in_tx_done  in  1  one-cycle strobe: transmitter finished the current byte
- in_halt  in  1  pipeline has fetched the halt word 0xFFFFFFFF
- out_tx_data  out  8  byte to transmit
- out_tx_start  out  1  one-cycle strobe: start transmitting out_tx_data
- out_imem_addr  out  ADDR_W  instruction-memory word address
- out_imem_data  out  LEN  instruction word
- out_imem_write  out  1  one-cycle write strobe
- out_pc_enable  out  1  drives the fetch stage's in_pc_enable
- out_cpu_reset  out  1  active-low pipeline reset (0 = hold pipeline in reset)

## Operation
- Commands are the first byte received in IDLE:
  - 0x01 LOAD
  - 0x02 RUN
  - 0x03 STEP
  - 0x04 HALT
  - Any other byte is ignored; the block stays in IDLE.
- States: IDLE, LOAD_COUNT, LOAD_BYTE, WRITE, RUN, STEP, SEND, WAIT_TX.
- LOAD sequence:
  - LOAD → LOAD_COUNT. The next byte is N, the word count.
  - N=0 → SEND with ack 0x00; no writes.
  - Otherwise → LOAD_BYTE. Each word is 4 bytes, MSB first.
  - After the 4th byte → WRITE: one-cycle out_imem_write at the current address, then address+1.
  - After N words → SEND with ack byte N; otherwise back to LOAD_BYTE.
  - Address restarts at 0 on every LOAD.
  - out_cpu_reset=0 from entry into LOAD_COUNT until return to IDLE.
- RUN: out_pc_enable=1 every cycle until in_halt=1 or a HALT byte arrives, then SEND 0x48. Other bytes in RUN are ignored.
- STEP: out_pc_enable=1 for exactly one cycle, then SEND 0x53.
- HALT received in IDLE → SEND 0x48.
- SEND: out_tx_start pulses one cycle with out_tx_data held → WAIT_TX. On in_tx_done → IDLE.
- in_rx_done strobes during SEND/WAIT_TX/STEP/WRITE are dropped.

## Timing
- Reset values:
  - state IDLE
  - out_tx_data=0x00
  - out_tx_start=0
  - out_imem_addr=0
  - out_imem_data=0
  - out_imem_write=0
  - out_pc_enable=0
  - out_cpu_reset=1
- All outputs are registered.
- Write latency: out_imem_write is high in the cycle after the in_rx_done carrying byte 4. out_imem_addr/out_imem_data are stable in that cycle.
- out_pc_enable rises the cycle after the RUN byte's in_rx_done. It falls the cycle after in_halt or the HALT byte.
- in_halt and a HALT byte in the same cycle: a single 0x48 ack.
- out_tx_start is high in the cycle after entering SEND.
- Address wraps from 2^ADDR_W-1 to 0; this cannot occur with N≤255 at ADDR_W=8.
- Reset asserted mid-operation: immediate return to reset values, a partial word is discarded, and out_cpu_reset goes to 1.

## Structure
- Shared package `debug_pkg`:
  - command opcodes CMD_LOAD/CMD_RUN/CMD_STEP/CMD_HALT
  - ack codes ACK_HALT=0x48, ACK_STEP=0x53
  - state encoding
- Sub-module `word_assembler`: shifts in bytes MSB first, counts 0–3, and emits a word-valid strobe. It is cleared on LOAD entry and on reset.
- The top-level FSM, address counter, word counter and TX sequencing live in debug_loader.

## Test plan
- Bytes 0x01,0x02 then DE AD BE EF 00 00 00 2A → two writes: addr0=0xDEADBEEF, addr1=0x0000002A. Ack 0x02. out_cpu_reset low throughout the load.
- Bytes 0x01,0x00 → no out_imem_write; single ack 0x00; return to IDLE.
- 0x02 RUN, in_halt after 10 cycles → out_pc_enable high for exactly 10 cycles; ack 0x48.
- 0x03 STEP twice (each acked via in_tx_done) → two single-cycle out_pc_enable pulses; two acks 0x53.
- In RUN, HALT byte coincident with in_halt → one out_tx_start with 0x48. A 0x07 byte in IDLE → no response.
- Reset asserted after 2 bytes of a word → outputs return to reset values. A fresh LOAD of 1 word writes addr0 with only the new bytes.

Source files
------------

// File: rtl/debug_pkg.sv
// debug_pkg: command opcodes, ack codes and FSM state encoding for the debug loader
package debug_pkg;
  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_RUN  = 8'h02;
  localparam logic [7:0] CMD_STEP = 8'h03;
  localparam logic [7:0] CMD_HALT = 8'h04;
  localparam logic [7:0] ACK_HALT = 8'h48;
  localparam logic [7:0] ACK_STEP = 8'h53;
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_COUNT, S_LOAD_BYTE, S_WRITE, S_RUN, S_STEP, S_SEND, S_WAIT_TX
  } state_t;
endpackage

// File: rtl/word_assembler.sv
// word_assembler: packs bytes MSB first into a word, strobing word_valid with the last byte
module word_assembler #(
  parameter int LEN = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           byte_valid,
  input  logic [7:0]     byte_data,
  output logic [LEN-1:0] word,
  output logic           word_valid
);
  localparam int CW = $clog2(LEN / 8);
  logic [LEN-9:0] shift;
  logic [CW-1:0]  cnt;
  // word is combinational so the top can register it in the same edge as the final byte
  assign word       = {shift, byte_data};
  assign word_valid = byte_valid && cnt == CW'(LEN / 8 - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift <= '0;
      cnt   <= '0;
    end else if (clear) begin
      shift <= '0;
      cnt   <= '0;
    end else if (byte_valid) begin
      shift <= word[LEN-9:0];
      cnt   <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/debug_loader.sv
// debug_loader: UART-driven instruction loader and run/step/halt controller for the pipeline
module debug_loader
  import debug_pkg::*;
#(
  parameter int LEN    = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_rx_data,
  input  logic              in_rx_done,
  input  logic              in_tx_done,
  input  logic              in_halt,
  output logic [7:0]        out_tx_data,
  output logic              out_tx_start,
  output logic [ADDR_W-1:0] out_imem_addr,
  output logic [LEN-1:0]    out_imem_data,
  output logic              out_imem_write,
  output logic              out_pc_enable,
  output logic              out_cpu_reset
);
  state_t state, state_n;
  logic [7:0] n_words, n_words_n, word_cnt, word_cnt_n, tx_data_n;
  logic [ADDR_W-1:0] addr_n;
  logic [LEN-1:0] data_n, word;
  logic tx_start_n, write_n, pc_en_n, cpu_reset_n, word_valid, load_start;
  assign load_start = state == S_IDLE && in_rx_done && in_rx_data == CMD_LOAD;
  word_assembler #(.LEN(LEN)) u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (load_start),
    .byte_valid (in_rx_done && state == S_LOAD_BYTE),
    .byte_data  (in_rx_data),
    .word       (word),
    .word_valid (word_valid)
  );
  always_comb begin
    state_n     = state;
    n_words_n   = n_words;
    word_cnt_n  = word_cnt;
    tx_data_n   = out_tx_data;
    addr_n      = out_imem_addr;
    data_n      = out_imem_data;
    tx_start_n  = 1'b0;
    write_n     = 1'b0;
    pc_en_n     = 1'b0;
    cpu_reset_n = out_cpu_reset;
    case (state)
      S_IDLE: if (in_rx_done) begin
        if (in_rx_data == CMD_LOAD) begin
          state_n     = S_LOAD_COUNT;
          addr_n      = '0;
          cpu_reset_n = 1'b0;
        end else if (in_rx_data == CMD_RUN) begin
          state_n = S_RUN;
          pc_en_n = 1'b1;
        end else if (in_rx_data == CMD_STEP) begin
          state_n = S_STEP;
          pc_en_n = 1'b1;
        end else if (in_rx_data == CMD_HALT) begin
          state_n   = S_SEND;
          tx_data_n = ACK_HALT;
        end
      end
      S_LOAD_COUNT: if (in_rx_done) begin
        n_words_n  = in_rx_data;
        word_cnt_n = '0;
        state_n    = in_rx_data == 8'h00 ? S_SEND : S_LOAD_BYTE;
        tx_data_n  = in_rx_data == 8'h00 ? 8'h00 : out_tx_data;
      end
      S_LOAD_BYTE: if (word_valid) begin
        state_n = S_WRITE;
        write_n = 1'b1;
        data_n  = word;
      end
      S_WRITE: begin
        addr_n     = out_imem_addr + 1'b1;
        word_cnt_n = word_cnt + 8'd1;
        state_n    = word_cnt_n == n_words ? S_SEND : S_LOAD_BYTE;
        tx_data_n  = word_cnt_n == n_words ? n_words : out_tx_data;
      end
      S_RUN: begin
        state_n   = in_halt || (in_rx_done && in_rx_data == CMD_HALT) ? S_SEND : S_RUN;
        tx_data_n = state_n == S_SEND ? ACK_HALT : out_tx_data;
        pc_en_n   = state_n == S_RUN;
      end
      S_STEP: begin
        state_n   = S_SEND;
        tx_data_n = ACK_STEP;
      end
      S_SEND: begin
        state_n    = S_WAIT_TX;
        tx_start_n = 1'b1;
      end
      S_WAIT_TX: if (in_tx_done) begin
        state_n     = S_IDLE;
        cpu_reset_n = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      n_words        <= '0;
      word_cnt       <= '0;
      out_tx_data    <= '0;
      out_tx_start   <= 1'b0;
      out_imem_addr  <= '0;
      out_imem_data  <= '0;
      out_imem_write <= 1'b0;
      out_pc_enable  <= 1'b0;
      out_cpu_reset  <= 1'b1;
    end else begin
      state          <= state_n;
      n_words        <= n_words_n;
      word_cnt       <= word_cnt_n;
      out_tx_data    <= tx_data_n;
      out_tx_start   <= tx_start_n;
      out_imem_addr  <= addr_n;
      out_imem_data  <= data_n;
      out_imem_write <= write_n;
      out_pc_enable  <= pc_en_n;
      out_cpu_reset  <= cpu_reset_n;
    end
  end
endmodule

// File: tb/tb_debug_loader.sv
// tb_debug_loader: scoreboard bench for debug_loader (writes and acks checked as the DUT emits them)
module tb_debug_loader;
  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;
  logic clk = 1'b0, reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_done = 1'b0, tx_done = 1'b0, halt = 1'b0;
  logic [7:0] tx_data, imem_addr;
  logic [31:0] imem_data;
  logic tx_start, imem_write, pc_enable, cpu_reset;
  int vectors = 0, errors = 0, pc_cnt = 0, wr_cnt = 0, tx_cnt = 0;
  wr_t exp_wr[$];
  logic [7:0] exp_ack[$];

  debug_loader #(.LEN(32), .ADDR_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_rx_data     (rx_data),
    .in_rx_done     (rx_done),
    .in_tx_done     (tx_done),
    .in_halt        (halt),
    .out_tx_data    (tx_data),
    .out_tx_start   (tx_start),
    .out_imem_addr  (imem_addr),
    .out_imem_data  (imem_data),
    .out_imem_write (imem_write),
    .out_pc_enable  (pc_enable),
    .out_cpu_reset  (cpu_reset)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running required done");
    $fatal(1);
  end

  // Scoreboard: memory writes and ack bytes are compared in order of emission
  always @(negedge clk) begin
    wr_t e;
    logic [7:0] a;
    if (reset) begin
      if (pc_enable) pc_cnt++;
      if (imem_write) begin
        wr_cnt++;
        vectors++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%0h data=%h, required no write", imem_addr, imem_data);
        end else begin
          e = exp_wr.pop_front();
          if (imem_addr !== e.a || imem_data !== e.d) begin
            errors++;
            $display("FAIL imem_write: got addr=%0h data=%h, required addr=%0h data=%h", imem_addr, imem_data, e.a, e.d);
          end
        end
      end
      if (tx_start) begin
        tx_cnt++;
        vectors++;
        if (exp_ack.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: got %h, required no ack", tx_data);
        end else begin
          a = exp_ack.pop_front();
          if (tx_data !== a) begin
            errors++;
            $display("FAIL ack: got %h, required %h", tx_data, a);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_ack();
    int i;
    for (i = 0; i < 50 && !tx_start; i++) @(negedge clk);
    if (!tx_start) begin
      vectors++;
      errors++;
      $display("FAIL ack_timeout: got no out_tx_start, required one within 50 cycles");
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    vectors++;
    if ({tx_data, tx_start, imem_addr, imem_data, imem_write, pc_enable, cpu_reset} !== {8'h00, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL %s: got tx=%h st=%b addr=%h data=%h wr=%b pc=%b crst=%b, required 00 0 00 00000000 0 0 1",
               tag, tx_data, tx_start, imem_addr, imem_data, imem_write, pc_enable, cpu_reset);
    end
  endtask

  task automatic check_cpu_reset(input string tag, input logic req);
    vectors++;
    if (cpu_reset !== req) begin
      errors++;
      $display("FAIL %s: got cpu_reset=%b, required %b", tag, cpu_reset, req);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset_values");
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("after_release");
  endtask

  task automatic test_load_two();
    logic [7:0] bytes [8] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h2A};
    int w0 = wr_cnt;
    exp_wr.push_back('{8'h00, 32'hDEADBEEF});
    exp_wr.push_back('{8'h01, 32'h0000002A});
    exp_ack.push_back(8'h02);
    send_byte(8'h01);
    check_cpu_reset("load_count_cpu_reset", 1'b0);
    send_byte(8'h02);
    for (int i = 0; i < 8; i++) begin
      send_byte(bytes[i]);
      if (i == 3 || i == 7) check_cpu_reset("load_cpu_reset", 1'b0);
    end
    wait_ack();
    check_cpu_reset("load_done_cpu_reset", 1'b1);
    vectors++;
    if (wr_cnt - w0 !== 2) begin
      errors++;
      $display("FAIL load_two_count: got %0d writes, required 2", wr_cnt - w0);
    end
  endtask

  task automatic test_load_zero();
    int w0 = wr_cnt;
    exp_ack.push_back(8'h00);
    send_byte(8'h01);
    send_byte(8'h00);
    wait_ack();
    vectors++;
    if (wr_cnt !== w0) begin
      errors++;
      $display("FAIL load_zero_writes: got %0d writes, required 0", wr_cnt - w0);
    end
    check_cpu_reset("load_zero_idle", 1'b1);
  endtask

  task automatic test_run();
    exp_ack.push_back(8'h48);
    pc_cnt = 0;
    @(negedge clk);
    rx_data = 8'h02;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (9) @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    wait_ack();
    vectors++;
    if (pc_cnt !== 10) begin
      errors++;
      $display("FAIL run_pc_cycles: got %0d, required 10", pc_cnt);
    end
  endtask

  task automatic test_step();
    for (int k = 0; k < 2; k++) begin
      exp_ack.push_back(8'h53);
      pc_cnt = 0;
      send_byte(8'h03);
      wait_ack();
      vectors++;
      if (pc_cnt !== 1) begin
        errors++;
        $display("FAIL step_pc_cycles[%0d]: got %0d, required 1", k, pc_cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    exp_ack.push_back(8'h48);
    t0 = tx_cnt;
    send_byte(8'h02);
    send_byte(8'h55);
    vectors++;
    if (pc_enable !== 1'b1) begin
      errors++;
      $display("FAIL run_ignores_byte: got pc_enable=%b, required 1", pc_enable);
    end
    @(negedge clk);
    rx_data = 8'h04;
    rx_done = 1'b1;
    halt = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    halt = 1'b0;
    wait_ack();
    repeat (10) @(negedge clk);
    vectors++;
    if (tx_cnt - t0 !== 1) begin
      errors++;
      $display("FAIL coincident_halt: got %0d acks, required 1", tx_cnt - t0);
    end
    t0 = tx_cnt;
    pc_cnt = 0;
    send_byte(8'h07);
    repeat (20) @(negedge clk);
    vectors++;
    if (tx_cnt !== t0 || pc_cnt !== 0) begin
      errors++;
      $display("FAIL bad_cmd: got acks=%0d pc=%0d, required 0 0", tx_cnt - t0, pc_cnt);
    end
  endtask

  task automatic test_reset_mid();
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'hDE);
    send_byte(8'hAD);
    check_cpu_reset("mid_load_cpu_reset", 1'b0);
    #2 reset = 1'b0;
    #1 check_reset_values("async_reset_mid");
    @(negedge clk);
    reset = 1'b1;
    exp_wr.push_back('{8'h00, 32'h12345678});
    exp_ack.push_back(8'h01);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    wait_ack();
    check_cpu_reset("reload_idle", 1'b1);
  endtask

  initial begin
    test_reset();
    test_load_two();
    test_load_zero();
    test_run();
    test_step();
    test_back_to_back();
    test_reset_mid();
    repeat (5) @(negedge clk);
    vectors++;
    if (exp_wr.size() != 0 || exp_ack.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d writes %0d acks pending, required 0 0", exp_wr.size(), exp_ack.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
